// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, issues one fetch at a time and
// advances or redirects the PC when the in-flight instruction retires.
module pc_sequencer #(
   parameter int unsigned             ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC       = '0,
   parameter int unsigned             INSTR_BYTES    = 4,
   parameter int unsigned             TIMEOUT_CYCLES = 64,
   parameter int unsigned             CNT_WIDTH      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  stall_i,
   input  logic                  retire_i,
   input  logic                  alu_branch_taken_i,
   input  logic                  is_jump_i,
   input  logic [ADDR_WIDTH-1:0] target_i,
   input  logic                  halt_i,
   output logic                  valid_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  busy_o,
   output logic                  halted_o,
   output logic                  misaligned_o,
   output logic                  timeout_o,
   output logic [CNT_WIDTH-1:0]  instr_count_o
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic                  mis_q, mis_d;
   logic                  to_q, to_d;

   logic                  redirect;
   logic                  target_misaligned;
   logic [ADDR_WIDTH-1:0] next_pc;

   // Resolve the PC that follows the retiring instruction
   always_comb begin
      redirect          = alu_branch_taken_i | is_jump_i;
      target_misaligned = redirect && ((target_i & ALIGN_MASK) != '0);
      next_pc           = redirect ? target_i : (pc_q + PC_STEP);
   end

   // Next-state logic for the sequencing FSM and its registers
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      wait_d  = wait_q;
      mis_d   = mis_q;
      to_d    = to_q;

      unique case (state_q)
         ST_IDLE: begin
            if (en_i && !stall_i) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (!stall_i) begin
               state_d = ST_WAIT;
               wait_d  = '0;
            end
         end

         ST_WAIT: begin
            if (retire_i) begin
               if (count_q != '1) begin
                  count_d = count_q + CNT_WIDTH'(1);
               end
               if (halt_i) begin
                  state_d = ST_HALT;
                  pc_d    = next_pc;
               end else if (target_misaligned) begin
                  // PC stays on the faulting instruction
                  state_d = ST_HALT;
                  mis_d   = 1'b1;
               end else begin
                  pc_d    = next_pc;
                  state_d = en_i ? ST_FETCH : ST_IDLE;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = ST_HALT;
               to_d    = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         count_q <= '0;
         wait_q  <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         wait_q  <= wait_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
      end
   end

   // Outputs; only valid_o looks at an input (stall_i)
   always_comb begin
      valid_o       = (state_q == ST_FETCH) && !stall_i;
      pc_o          = pc_q;
      busy_o        = (state_q == ST_FETCH) || (state_q == ST_WAIT);
      halted_o      = (state_q == ST_HALT);
      misaligned_o  = mis_q;
      timeout_o     = to_q;
      instr_count_o = count_q;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: random instruction stream against a reference
// model; expected fetch PCs are queued and checked when valid_o appears.
module tb_pc_sequencer;

   localparam int unsigned AW   = 8;
   localparam int unsigned CW   = 4;
   localparam int unsigned TO   = 8;
   localparam int          CMAX = (1 << CW) - 1;

   logic          clk_i;
   logic          rst_ni;
   logic          en_i;
   logic          stall_i;
   logic          retire_i;
   logic          alu_branch_taken_i;
   logic          is_jump_i;
   logic [AW-1:0] target_i;
   logic          halt_i;
   logic          valid_o;
   logic [AW-1:0] pc_o;
   logic          busy_o;
   logic          halted_o;
   logic          misaligned_o;
   logic          timeout_o;
   logic [CW-1:0] instr_count_o;

   pc_sequencer #(
      .ADDR_WIDTH     (AW),
      .RESET_PC       (8'h00),
      .INSTR_BYTES    (4),
      .TIMEOUT_CYCLES (TO),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .en_i               (en_i),
      .stall_i            (stall_i),
      .retire_i           (retire_i),
      .alu_branch_taken_i (alu_branch_taken_i),
      .is_jump_i          (is_jump_i),
      .target_i           (target_i),
      .halt_i             (halt_i),
      .valid_o            (valid_o),
      .pc_o               (pc_o),
      .busy_o             (busy_o),
      .halted_o           (halted_o),
      .misaligned_o       (misaligned_o),
      .timeout_o          (timeout_o),
      .instr_count_o      (instr_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int vectors     = 0;
   int miscompares = 0;

   // Expected fetch PCs, in issue order
   logic [AW-1:0] exp_q[$];

   // Architectural reference state
   logic [AW-1:0] m_pc;
   int            m_cnt;
   bit            m_halt;
   bit            m_mis;
   bit            m_to;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every fetch request must match the next expected PC
   always @(negedge clk_i) begin
      if (valid_o) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL fetch_unexpected: got valid pc %0h expected no fetch at %0t", pc_o, $time);
         end else begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            if (pc_o !== e) begin
               miscompares++;
               $display("FAIL fetch_pc: got %0h expected %0h at %0t", pc_o, e, $time);
            end
         end
      end
   end

   task automatic check_state(input string tag);
      chk({tag, "_pc"},     32'(pc_o),          32'(m_pc));
      chk({tag, "_count"},  32'(instr_count_o), 32'(m_cnt));
      chk({tag, "_halted"}, 32'(halted_o),      32'(m_halt));
      chk({tag, "_misal"},  32'(misaligned_o),  32'(m_mis));
      chk({tag, "_tmo"},    32'(timeout_o),     32'(m_to));
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_pc   = '0;
      m_cnt  = 0;
      m_halt = 1'b0;
      m_mis  = 1'b0;
      m_to   = 1'b0;
   endtask

   task automatic junk_fields();
      alu_branch_taken_i = 1'($urandom_range(0, 1));
      is_jump_i          = 1'($urandom_range(0, 1));
      halt_i             = 1'($urandom_range(0, 1));
      target_i           = AW'($urandom);
   endtask

   // Reset, check reset values, release with enable raised; ends at a negedge
   task automatic do_reset();
      rst_ni   = 1'b0;
      en_i     = 1'b0;
      stall_i  = 1'b0;
      retire_i = 1'b0;
      junk_fields();
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_state("rst");
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy",  32'(busy_o),  32'd0);
      rst_ni = 1'b1;
      en_i   = 1'b1;
      exp_q.push_back(m_pc);
   endtask

   // Wait (bounded) for the pending fetch to issue, with random stalls
   task automatic issue_wait(output bit ok);
      ok = valid_o;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk_i);
         #1 stall_i = ($urandom_range(0, 3) == 0);
         @(negedge clk_i);
         chk("prefetch_pc", 32'(pc_o), 32'(m_pc));
         ok = valid_o;
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL issue_timeout: got no valid_o expected fetch of pc %0h within 40 cycles", m_pc);
      end
      stall_i = 1'b0;
   endtask

   // One instruction: issue, retire after dly WAIT cycles, check the result
   task automatic run_instr(input bit br, input bit jmp, input logic [AW-1:0] tgt,
                            input bit hlt, input int dly, input bit en_after, input bit st);
      bit            ok;
      logic [AW-1:0] nxt;
      issue_wait(ok);
      if (!ok) begin
         do_reset();
         return;
      end
      @(posedge clk_i);
      #1 chk("wait_busy", 32'(busy_o), 32'd1);
      repeat (dly) @(posedge clk_i);
      #1;
      retire_i           = 1'b1;
      alu_branch_taken_i = br;
      is_jump_i          = jmp;
      target_i           = tgt;
      halt_i             = hlt;
      en_i               = en_after;

      nxt = (br || jmp) ? tgt : m_pc + AW'(4);
      if (m_cnt < CMAX) m_cnt++;
      if (hlt) begin
         m_pc   = nxt;
         m_halt = 1'b1;
      end else if ((br || jmp) && (tgt % 4 != 0)) begin
         m_halt = 1'b1;
         m_mis  = 1'b1;
      end else begin
         m_pc = nxt;
         if (en_after) exp_q.push_back(m_pc);
      end

      @(posedge clk_i);
      #1 retire_i = 1'b0;
      junk_fields();
      stall_i = st;
      @(negedge clk_i);
      check_state("retire");
      chk("retire_busy",  32'(busy_o),  32'(!m_halt && en_after));
      chk("retire_valid", 32'(valid_o), 32'(!m_halt && en_after && !st));

      if (!m_halt && !en_after) begin
         // Stray retire while idle must change nothing
         @(posedge clk_i);
         #1 retire_i = 1'b1;
         is_jump_i = 1'b1;
         target_i  = AW'($urandom) & 8'hFC;
         @(posedge clk_i);
         #1 retire_i = 1'b0;
         @(negedge clk_i);
         check_state("idle");
         chk("idle_busy", 32'(busy_o), 32'd0);
         en_i = 1'b1;
         exp_q.push_back(m_pc);
      end
   endtask

   // Issue and never retire: halt with timeout after TO WAIT cycles
   task automatic run_timeout();
      bit ok;
      issue_wait(ok);
      if (!ok) begin
         do_reset();
         return;
      end
      @(posedge clk_i);
      repeat (TO - 1) @(posedge clk_i);
      @(negedge clk_i);
      chk("pre_tmo_halted", 32'(halted_o),  32'd0);
      chk("pre_tmo_flag",   32'(timeout_o), 32'd0);
      chk("pre_tmo_busy",   32'(busy_o),    32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      m_halt = 1'b1;
      m_to   = 1'b1;
      check_state("tmo");
   endtask

   // HALT absorbs everything, including retire pulses
   task automatic halt_check();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i);
         #1 retire_i = 1'b1;
         en_i    = 1'b1;
         stall_i = 1'b0;
         junk_fields();
         @(negedge clk_i);
         check_state("halt");
         chk("halt_valid", 32'(valid_o), 32'd0);
         chk("halt_busy",  32'(busy_o),  32'd0);
      end
      retire_i = 1'b0;
   endtask

   // Reset asserted mid-WAIT takes effect before the next clock edge
   task automatic run_async_reset();
      bit ok;
      issue_wait(ok);
      if (!ok) begin
         do_reset();
         return;
      end
      @(posedge clk_i);
      #3 rst_ni = 1'b0;
      model_reset();
      #1;
      check_state("arst");
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_busy",  32'(busy_o),  32'd0);
      do_reset();
   endtask

   initial begin
      bit            ok;
      bit            br, jmp, hlt, en_after, st;
      logic [AW-1:0] tgt;
      int            dly, r;

      rst_ni = 1'b0;
      do_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      chk("first_fetch_valid", 32'(valid_o), 32'd1);

      // Sequential run, then counter saturation
      for (int i = 0; i < 3; i++) run_instr(0, 0, 8'h00, 0, 2, 1, 0);
      chk("seq_count3", 32'(instr_count_o), 32'd3);
      chk("seq_pc",     32'(pc_o),          32'h0C);
      for (int i = 0; i < 13; i++) run_instr(0, 0, 8'h00, 0, i % 8, 1, (i % 3) == 0);
      chk("count_sat", 32'(instr_count_o), 32'(CMAX));

      // Redirects, wrap, retire on the last WAIT cycle, idle, stall
      run_instr(1, 0, 8'h80, 0, 1, 1, 0);
      run_instr(0, 1, 8'h40, 0, 1, 1, 0);
      run_instr(1, 1, 8'h20, 0, 1, 1, 0);
      run_instr(0, 1, 8'hFC, 0, 0, 1, 0);
      run_instr(0, 0, 8'h00, 0, 0, 1, 0);
      chk("wrap_pc", 32'(pc_o), 32'h00);
      run_instr(0, 0, 8'h00, 0, TO - 1, 1, 0);
      chk("late_retire_no_tmo", 32'(timeout_o), 32'd0);
      run_instr(0, 0, 8'h00, 0, 1, 0, 0);
      run_instr(1, 0, 8'h10, 0, 0, 1, 1);

      // Misaligned redirect, then halt beating the misaligned target
      run_instr(0, 1, 8'h12, 0, 3, 1, 0);
      chk("misal_pc", 32'(pc_o), 32'h10);
      halt_check();
      do_reset();
      run_instr(0, 1, 8'h12, 1, 2, 1, 0);
      chk("halt_misal_flag", 32'(misaligned_o), 32'd0);
      halt_check();
      do_reset();

      run_timeout();
      halt_check();
      do_reset();
      run_async_reset();

      // Random instruction stream
      for (int n = 0; n < 150; n++) begin
         if (m_halt) begin
            halt_check();
            do_reset();
         end
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            run_timeout();
         end else if (r < 5) begin
            run_async_reset();
         end else begin
            br       = ($urandom_range(0, 3) == 0);
            jmp      = ($urandom_range(0, 4) == 0);
            tgt      = AW'($urandom);
            if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
            hlt      = ($urandom_range(0, 29) == 0);
            dly      = int'($urandom_range(0, TO - 1));
            en_after = ($urandom_range(0, 4) != 0);
            st       = ($urandom_range(0, 3) == 0);
            run_instr(br, jmp, tgt, hlt, dly, en_after, st);
         end
      end

      if (m_halt) halt_check();
      else issue_wait(ok);
      repeat (2) @(negedge clk_i);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog: got no end of test expected finish before 2ms");
      $fatal(1);
   end

endmodule
